tpu_systolic_top: RTL and testbench

Top level of a 32×32 output-stationary systolic-array matrix-multiply engine. On `tpu_start` it computes three independent 32×32 tiles, C = D × W, with 16-bit signed operands. Operands stream from eight weight SRAMs and eight data SRAMs, and each tile's 32-bit results are written row-by-row into output banks a, b and c. `tpu_done` reports completion to the host controller.

---
 rtl/tpu_pkg.sv | 32 +++
 rtl/tpu_pe.sv | 49 ++++
 rtl/tpu_systolic_top.sv | 249 ++++++++++++++++++++++++
 tb/tb_tpu_systolic_top.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
//============================================================================
// Module      : tpu_pkg
// Description : Shared types and constants for the 32x32 systolic matmul engine.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } tpu_state_e;

    localparam int NUM_TILES      = 3;
    localparam int COMPUTE_CYCLES = 96;
    localparam int WRITE_CYCLES   = 32;
    localparam int FEED_CYCLES    = 32;
    localparam int LANE_WIDTH     = 16;
    localparam int LANES_PER_WORD = 4;
    localparam int NUM_SRAMS      = 8;
    localparam int ADDR_WIDTH     = 10;
    localparam int WADDR_WIDTH    = 6;
    localparam int CNT_WIDTH      = 7;
    localparam int TILE_WIDTH     = 2;
    localparam int K_WIDTH        = 5;

endpackage

`default_nettype wire

// File: rtl/tpu_pe.sv
//============================================================================
// Module      : tpu_pe
// Description : Output-stationary MAC cell with data/weight pass-through regs.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tpu_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_weight,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [DATA_WIDTH-1:0] o_weight,
    output logic [ACC_WIDTH-1:0]  o_acc
);

    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_weight;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ACC_WIDTH-1:0]  w_prod;

    // Operands are sign-extended so the low ACC_WIDTH bits hold the signed product.
    assign w_prod = $signed({{(ACC_WIDTH-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data})
                  * $signed({{(ACC_WIDTH-DATA_WIDTH){i_weight[DATA_WIDTH-1]}}, i_weight});

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_data   <= '0;
            r_weight <= '0;
            r_acc    <= '0;
        end else begin
            r_data   <= i_data;
            r_weight <= i_weight;
            r_acc    <= i_clr ? '0 : r_acc + w_prod;
        end
    end

    assign o_data   = r_data;
    assign o_weight = r_weight;
    assign o_acc    = r_acc;

endmodule

`default_nettype wire

// File: rtl/tpu_systolic_top.sv
//============================================================================
// Module      : tpu_systolic_top
// Description : 32x32 output-stationary systolic engine computing three tiles
//               C = D x W; optional ReLU on written results via TPU_RELU_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tpu_systolic_top
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE        = 32,
    parameter int SRAM_DATA_WIDTH   = 64,
    parameter int DATA_WIDTH        = 16,
    parameter int OUTPUT_DATA_WIDTH = 32
) (
    input  logic                                     clk,
    input  logic                                     srstn,
    input  logic                                     tpu_start,
    input  logic [SRAM_DATA_WIDTH-1:0]               sram_rdata_w0, sram_rdata_w1, sram_rdata_w2, sram_rdata_w3,
    input  logic [SRAM_DATA_WIDTH-1:0]               sram_rdata_w4, sram_rdata_w5, sram_rdata_w6, sram_rdata_w7,
    input  logic [SRAM_DATA_WIDTH-1:0]               sram_rdata_d0, sram_rdata_d1, sram_rdata_d2, sram_rdata_d3,
    input  logic [SRAM_DATA_WIDTH-1:0]               sram_rdata_d4, sram_rdata_d5, sram_rdata_d6, sram_rdata_d7,
    output logic [ADDR_WIDTH-1:0]                    sram_raddr_w0, sram_raddr_w1, sram_raddr_w2, sram_raddr_w3,
    output logic [ADDR_WIDTH-1:0]                    sram_raddr_w4, sram_raddr_w5, sram_raddr_w6, sram_raddr_w7,
    output logic [ADDR_WIDTH-1:0]                    sram_raddr_d0, sram_raddr_d1, sram_raddr_d2, sram_raddr_d3,
    output logic [ADDR_WIDTH-1:0]                    sram_raddr_d4, sram_raddr_d5, sram_raddr_d6, sram_raddr_d7,
    output logic                                     sram_write_enable_a0, sram_write_enable_b0, sram_write_enable_c0,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]  sram_wdata_a, sram_wdata_b, sram_wdata_c,
    output logic [WADDR_WIDTH-1:0]                   sram_waddr_a, sram_waddr_b, sram_waddr_c,
    output logic                                     tpu_done
);

    tpu_state_e                 r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]       r_cnt, w_cnt_nxt;
    logic [TILE_WIDTH-1:0]      r_tile, w_tile_nxt;
    logic                       w_clr;
    logic [ADDR_WIDTH-1:0]      r_raddr, w_raddr_nxt;
    logic                       r_vld;
    logic                       r_done;
    logic                       r_we_a, r_we_b, r_we_c;
    logic [WADDR_WIDTH-1:0]     r_waddr;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] r_wdata, w_row;
    logic [OUTPUT_DATA_WIDTH-1:0] w_lane;

    logic [NUM_SRAMS*LANES_PER_WORD*LANE_WIDTH-1:0] w_wvec, w_dvec;
    logic [DATA_WIDTH-1:0]        w_wfeed [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]        w_dfeed [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]        w_wcol  [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]        w_drow  [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]        w_dbus  [ARRAY_SIZE][ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]        w_wbus  [ARRAY_SIZE][ARRAY_SIZE];
    logic [OUTPUT_DATA_WIDTH-1:0] w_acc   [ARRAY_SIZE][ARRAY_SIZE];
    logic [ARRAY_SIZE-1:0]        w_unused_d, w_unused_w;

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tile  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tile  <= w_tile_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tile_nxt  = r_tile;
        case (r_state)
            IDLE, DONE: begin
                if (tpu_start) begin
                    w_state_nxt = COMPUTE;
                    w_cnt_nxt   = '0;
                    w_tile_nxt  = '0;
                end
            end
            COMPUTE: begin
                if (r_cnt == CNT_WIDTH'(COMPUTE_CYCLES - 1)) begin
                    w_state_nxt = WRITE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WRITE: begin
                if (r_cnt == CNT_WIDTH'(WRITE_CYCLES - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_tile == TILE_WIDTH'(NUM_TILES - 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = COMPUTE;
                        w_tile_nxt  = r_tile + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Accumulators clear on the edge that enters COMPUTE; the pipeline is already zero-flushed then.
    assign w_clr = (w_state_nxt == COMPUTE) && (r_state != COMPUTE);

    always_comb begin
        w_raddr_nxt = '0;
        if ((w_state_nxt == COMPUTE) && (w_cnt_nxt < CNT_WIDTH'(FEED_CYCLES))) begin
            w_raddr_nxt = ADDR_WIDTH'({w_tile_nxt, w_cnt_nxt[K_WIDTH-1:0]});
        end
    end

    assign w_wvec = {sram_rdata_w7, sram_rdata_w6, sram_rdata_w5, sram_rdata_w4,
                     sram_rdata_w3, sram_rdata_w2, sram_rdata_w1, sram_rdata_w0};
    assign w_dvec = {sram_rdata_d7, sram_rdata_d6, sram_rdata_d5, sram_rdata_d4,
                     sram_rdata_d3, sram_rdata_d2, sram_rdata_d1, sram_rdata_d0};

    for (genvar l = 0; l < ARRAY_SIZE; l++) begin : g_lane
        assign w_wfeed[l] = r_vld ? w_wvec[l*LANE_WIDTH +: DATA_WIDTH] : '0;
        assign w_dfeed[l] = r_vld ? w_dvec[l*LANE_WIDTH +: DATA_WIDTH] : '0;

        if (l == 0) begin : g_direct
            assign w_wcol[l] = w_wfeed[l];
            assign w_drow[l] = w_dfeed[l];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_wsh [0:l-1];
            logic [DATA_WIDTH-1:0] r_dsh [0:l-1];
            always_ff @(posedge clk or negedge srstn) begin
                if (!srstn) begin
                    for (int k = 0; k < l; k++) begin
                        r_wsh[k] <= '0;
                        r_dsh[k] <= '0;
                    end
                end else begin
                    r_wsh[0] <= w_wfeed[l];
                    r_dsh[0] <= w_dfeed[l];
                    for (int k = 1; k < l; k++) begin
                        r_wsh[k] <= r_wsh[k-1];
                        r_dsh[k] <= r_dsh[k-1];
                    end
                end
            end
            assign w_wcol[l] = r_wsh[l-1];
            assign w_drow[l] = r_dsh[l-1];
        end
    end

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_row
        for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
            logic [DATA_WIDTH-1:0] w_din, w_win;
            if (j == 0) begin : g_dfirst
                assign w_din = w_drow[i];
            end else begin : g_dnext
                assign w_din = w_dbus[i][j-1];
            end
            if (i == 0) begin : g_wfirst
                assign w_win = w_wcol[j];
            end else begin : g_wnext
                assign w_win = w_wbus[i-1][j];
            end
            tpu_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (OUTPUT_DATA_WIDTH)
            ) u_pe (
                .clk      (clk),
                .srstn    (srstn),
                .i_clr    (w_clr),
                .i_data   (w_din),
                .i_weight (w_win),
                .o_data   (w_dbus[i][j]),
                .o_weight (w_wbus[i][j]),
                .o_acc    (w_acc[i][j])
            );
        end
        assign w_unused_d[i] = ^w_dbus[i][ARRAY_SIZE-1];
        assign w_unused_w[i] = ^w_wbus[ARRAY_SIZE-1][i];
    end

    always_comb begin
        w_row  = '0;
        w_lane = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            w_lane = w_acc[r_cnt[K_WIDTH-1:0]][j];
`ifdef TPU_RELU_EN
            if (w_lane[OUTPUT_DATA_WIDTH-1]) begin
                w_lane = '0;
            end
`endif
            w_row[j*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = w_lane;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_raddr <= '0;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
            r_we_a  <= 1'b0;
            r_we_b  <= 1'b0;
            r_we_c  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_raddr <= w_raddr_nxt;
            r_vld   <= (r_state == COMPUTE) && (r_cnt < CNT_WIDTH'(FEED_CYCLES));
            r_done  <= (r_state == DONE);
            r_we_a  <= (r_state == WRITE) && (r_tile == 2'd0);
            r_we_b  <= (r_state == WRITE) && (r_tile == 2'd1);
            r_we_c  <= (r_state == WRITE) && (r_tile == 2'd2);
            if (r_state == WRITE) begin
                r_waddr <= WADDR_WIDTH'(r_cnt[K_WIDTH-1:0]);
                r_wdata <= w_row;
            end
        end
    end

    assign sram_raddr_w0 = r_raddr;
    assign sram_raddr_w1 = r_raddr;
    assign sram_raddr_w2 = r_raddr;
    assign sram_raddr_w3 = r_raddr;
    assign sram_raddr_w4 = r_raddr;
    assign sram_raddr_w5 = r_raddr;
    assign sram_raddr_w6 = r_raddr;
    assign sram_raddr_w7 = r_raddr;
    assign sram_raddr_d0 = r_raddr;
    assign sram_raddr_d1 = r_raddr;
    assign sram_raddr_d2 = r_raddr;
    assign sram_raddr_d3 = r_raddr;
    assign sram_raddr_d4 = r_raddr;
    assign sram_raddr_d5 = r_raddr;
    assign sram_raddr_d6 = r_raddr;
    assign sram_raddr_d7 = r_raddr;

    assign sram_write_enable_a0 = r_we_a;
    assign sram_write_enable_b0 = r_we_b;
    assign sram_write_enable_c0 = r_we_c;
    assign sram_wdata_a         = r_wdata;
    assign sram_wdata_b         = r_wdata;
    assign sram_wdata_c         = r_wdata;
    assign sram_waddr_a         = r_waddr;
    assign sram_waddr_b         = r_waddr;
    assign sram_waddr_c         = r_waddr;
    assign tpu_done             = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tpu_systolic_top.sv
//============================================================================
// Module      : tb_tpu_systolic_top
// Description : Directed self-checking bench for tpu_systolic_top.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_tpu_systolic_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srstn;
    logic          tpu_start;
    logic [63:0]   rd_w [8];
    logic [63:0]   rd_d [8];
    logic [9:0]    ra_w [8];
    logic [9:0]    ra_d [8];
    logic          we_a, we_b, we_c;
    logic [1023:0] wd_a, wd_b, wd_c;
    logic [5:0]    wa_a, wa_b, wa_c;
    logic          done;

    logic [15:0]   wmem [0:1023][0:31];
    logic [15:0]   dmem [0:1023][0:31];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tpu_systolic_top dut (
        .clk(clk), .srstn(srstn), .tpu_start(tpu_start),
        .sram_rdata_w0(rd_w[0]), .sram_rdata_w1(rd_w[1]), .sram_rdata_w2(rd_w[2]), .sram_rdata_w3(rd_w[3]),
        .sram_rdata_w4(rd_w[4]), .sram_rdata_w5(rd_w[5]), .sram_rdata_w6(rd_w[6]), .sram_rdata_w7(rd_w[7]),
        .sram_rdata_d0(rd_d[0]), .sram_rdata_d1(rd_d[1]), .sram_rdata_d2(rd_d[2]), .sram_rdata_d3(rd_d[3]),
        .sram_rdata_d4(rd_d[4]), .sram_rdata_d5(rd_d[5]), .sram_rdata_d6(rd_d[6]), .sram_rdata_d7(rd_d[7]),
        .sram_raddr_w0(ra_w[0]), .sram_raddr_w1(ra_w[1]), .sram_raddr_w2(ra_w[2]), .sram_raddr_w3(ra_w[3]),
        .sram_raddr_w4(ra_w[4]), .sram_raddr_w5(ra_w[5]), .sram_raddr_w6(ra_w[6]), .sram_raddr_w7(ra_w[7]),
        .sram_raddr_d0(ra_d[0]), .sram_raddr_d1(ra_d[1]), .sram_raddr_d2(ra_d[2]), .sram_raddr_d3(ra_d[3]),
        .sram_raddr_d4(ra_d[4]), .sram_raddr_d5(ra_d[5]), .sram_raddr_d6(ra_d[6]), .sram_raddr_d7(ra_d[7]),
        .sram_write_enable_a0(we_a), .sram_write_enable_b0(we_b), .sram_write_enable_c0(we_c),
        .sram_wdata_a(wd_a), .sram_wdata_b(wd_b), .sram_wdata_c(wd_c),
        .sram_waddr_a(wa_a), .sram_waddr_b(wa_b), .sram_waddr_c(wa_c),
        .tpu_done(done)
    );

    // Synchronous-read SRAMs, each with its own address port; lane 4n+m is SRAM n, slot m.
    always @(posedge clk) begin
        for (int n = 0; n < 8; n++) begin
            for (int m = 0; m < 4; m++) begin
                rd_w[n][16*m +: 16] <= wmem[ra_w[n]][4*n+m];
                rd_d[n][16*m +: 16] <= dmem[ra_d[n]][4*n+m];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int bad;
        bad = 0;
        for (int j = 31; j >= 0; j--) begin
            if (obs[32*j +: 32] !== exp[32*j +: 32]) bad = j;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d lane %0d: observed %h expected %h",
                   tag, cyc, bad, obs[32*bad +: 32], exp[32*bad +: 32]);
        end
    endtask

    // Hand-derived results: mode 0 is all-zero SRAMs, mode 1 is identity / signed / wrap tiles.
    function automatic logic [31:0] exp_lane(input int mode, input int tile, input int i, input int j);
        if (mode == 0) return 32'h0;
        case (tile)
            0: return 32'(32*i + j);
`ifdef TPU_RELU_EN
            1: return 32'h0;
`else
            1: return 32'hFFFFFFC0;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1023:0] exp_row(input int mode, input int tile, input int r);
        logic [1023:0] v;
        for (int j = 0; j < 32; j++) v[32*j +: 32] = exp_lane(mode, tile, r, j);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_pulse();
        tpu_start = 1'b1;
        @(posedge clk);
        #1;
        tpu_start = 1'b0;
        cyc = 0;
    endtask

    // Checks every observable output against the nominal three-tile schedule.
    task automatic check_cycle(input int mode);
        int t, loc, ea, r;
        logic [2:0] we;
        t   = cyc / 128;
        loc = cyc % 128;
        ea  = (t < 3 && loc < 32) ? t*32 + loc : 0;
        chk("raddr_w", 64'(ra_w[cyc % 8]), 64'(ea));
        chk("raddr_d", 64'(ra_d[(cyc + 3) % 8]), 64'(ea));
        we = {we_c, we_b, we_a};
        for (int b = 0; b < 3; b++) begin
            if (cyc >= 97 + 128*b && cyc <= 128 + 128*b) begin
                r = cyc - 97 - 128*b;
                chk($sformatf("we_%0d", b), 64'(we[b]), 64'd1);
                case (b)
                    0: begin chk("waddr_a", 64'(wa_a), 64'(r)); chk_row("wdata_a", wd_a, exp_row(mode, 0, r)); end
                    1: begin chk("waddr_b", 64'(wa_b), 64'(r)); chk_row("wdata_b", wd_b, exp_row(mode, 1, r)); end
                    default: begin chk("waddr_c", 64'(wa_c), 64'(r)); chk_row("wdata_c", wd_c, exp_row(mode, 2, r)); end
                endcase
            end else begin
                chk($sformatf("we_%0d", b), 64'(we[b]), 64'd0);
            end
        end
        if (cyc >= 1) chk("done", 64'(done), (cyc >= 385) ? 64'd1 : 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_we"}, 64'({we_c, we_b, we_a}), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        srstn     = 1'b0;
        tpu_start = 1'b0;
        for (int a = 0; a < 1024; a++) begin
            for (int l = 0; l < 32; l++) begin
                wmem[a][l] = 16'h0;
                dmem[a][l] = 16'h0;
            end
        end

        // Reset held: start toggling must have no effect.
        for (int k = 0; k < 6; k++) begin
            tpu_start = k[0];
            step();
            check_quiet("rst");
            chk("rst_raddr", 64'(ra_w[k]), 64'd0);
            chk("rst_waddr", 64'(wa_b), 64'd0);
            chk_row("rst_wdata", wd_c, '0);
        end
        tpu_start = 1'b0;
        srstn     = 1'b1;
        step();
        step();
        check_quiet("idle");

        // Run A: all-zero SRAMs from IDLE.
        start_pulse();
        chk("A_done0", 64'(done), 64'd0);
        check_cycle(0);
        while (cyc < 390) begin
            step();
            check_cycle(0);
        end

        // Run B: tile0 identity, tile1 signed, tile2 wrap; restarted from DONE.
        for (int k = 0; k < 32; k++) begin
            for (int l = 0; l < 32; l++) begin
                wmem[k][l]      = (l == k) ? 16'd1 : 16'd0;
                dmem[k][l]      = 16'(32*l + k);
                wmem[32 + k][l] = 16'd2;
                dmem[32 + k][l] = 16'hFFFF;
                wmem[64 + k][l] = 16'h8000;
                dmem[64 + k][l] = 16'h8000;
            end
        end
        step();
        start_pulse();
        chk("B_done_held", 64'(done), 64'd1);
        check_cycle(1);
        while (cyc < 390) begin
            step();
            check_cycle(1);
        end

        // Run C: busy start at cycle 50, asynchronous reset at cycle 200.
        start_pulse();
        chk("C_done_held", 64'(done), 64'd1);
        while (cyc < 200) begin
            step();
            check_cycle(1);
            if (cyc == 49) tpu_start = 1'b1;
            if (cyc == 50) tpu_start = 1'b0;
        end
        srstn = 1'b0;
        #1;
        check_quiet("mid_rst");
        chk("mid_rst_raddr", 64'(ra_d[2]), 64'd0);
        chk("mid_rst_waddr", 64'(wa_a), 64'd0);
        chk_row("mid_rst_wdata", wd_a, '0);
        for (int k = 0; k < 3; k++) step();
        srstn = 1'b1;
        while (cyc < 460) begin
            step();
            check_quiet("post_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
